// File: rtl/score_counter_multi.sv
// Multi-channel score counter: synchronised button edges drive per-channel bounded up/down counts
// with BCD digits and limit flags.
module score_counter_multi #(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned MAX_VAL = 99,
  parameter int unsigned CNT_BW  = 7,
  parameter bit          WRAP    = 1'b0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_CH-1:0]        up_i,
  input  logic [NUM_CH-1:0]        down_i,
  input  logic                     clear_i,
  output logic [NUM_CH*CNT_BW-1:0] cnt_o,
  output logic [NUM_CH*4-1:0]      tens_o,
  output logic [NUM_CH*4-1:0]      ones_o,
  output logic [NUM_CH-1:0]        at_max_o,
  output logic [NUM_CH-1:0]        at_min_o,
  output logic [NUM_CH-1:0]        changed_o
);

  localparam logic [CNT_BW-1:0] MaxCnt = CNT_BW'(MAX_VAL);
  localparam logic [CNT_BW-1:0] OneCnt = CNT_BW'(1);
  localparam logic [CNT_BW-1:0] TenCnt = CNT_BW'(10);

  // Assertion is immediate through the async set; release follows two clock edges.
  logic [1:0] rst_sync_q;
  logic       rst_int;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rst_sync_q <= 2'b11;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b0};
    end
  end

  assign rst_int = rst_sync_q[1];

  logic [NUM_CH-1:0] up_s1_q, up_s2_q, up_prev_q;
  logic [NUM_CH-1:0] dn_s1_q, dn_s2_q, dn_prev_q;
  logic [NUM_CH-1:0] up_ev, dn_ev;
  logic [NUM_CH-1:0][CNT_BW-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0] changed_q, changed_d;

  assign up_ev = up_s2_q & ~up_prev_q;
  assign dn_ev = dn_s2_q & ~dn_prev_q;

  always_comb begin
    cnt_d     = cnt_q;
    changed_d = '0;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      if (clear_i || (cnt_q[c] > MaxCnt)) begin
        cnt_d[c] = '0;
      end else if (up_ev[c] && !dn_ev[c]) begin
        if (cnt_q[c] == MaxCnt) begin
          cnt_d[c] = WRAP ? '0 : MaxCnt;
        end else begin
          cnt_d[c] = cnt_q[c] + OneCnt;
        end
      end else if (dn_ev[c] && !up_ev[c]) begin
        if (cnt_q[c] == '0) begin
          cnt_d[c] = WRAP ? MaxCnt : '0;
        end else begin
          cnt_d[c] = cnt_q[c] - OneCnt;
        end
      end
      changed_d[c] = (cnt_d[c] != cnt_q[c]);
    end
  end

  always_ff @(posedge clk_i or posedge rst_int) begin
    if (rst_int) begin
      up_s1_q   <= '0;
      up_s2_q   <= '0;
      up_prev_q <= '0;
      dn_s1_q   <= '0;
      dn_s2_q   <= '0;
      dn_prev_q <= '0;
      cnt_q     <= '0;
      changed_q <= '0;
    end else begin
      up_s1_q   <= up_i;
      up_s2_q   <= up_s1_q;
      up_prev_q <= up_s2_q;
      dn_s1_q   <= down_i;
      dn_s2_q   <= dn_s1_q;
      dn_prev_q <= dn_s2_q;
      cnt_q     <= cnt_d;
      changed_q <= changed_d;
    end
  end

  assign cnt_o     = cnt_q;
  assign changed_o = changed_q;

  always_comb begin
    tens_o   = '0;
    ones_o   = '0;
    at_max_o = '0;
    at_min_o = '0;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      tens_o[c*4 +: 4] = 4'(cnt_q[c] / TenCnt);
      ones_o[c*4 +: 4] = 4'(cnt_q[c] % TenCnt);
      at_max_o[c]      = (cnt_q[c] == MaxCnt);
      at_min_o[c]      = (cnt_q[c] == '0);
    end
  end

endmodule

// File: tb/tb_score_counter_multi.sv
// Scoreboard bench for score_counter_multi: a saturating and a wrapping instance share stimulus;
// expected count changes are queued at issue time and popped whenever changed_o pulses.
module tb_score_counter_multi;

  localparam int unsigned BW = 7;

  typedef struct packed {
    logic [1:0]  chg;
    logic [13:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clear = 1'b0;
  logic [1:0]  up = '0;
  logic [1:0]  dn = '0;
  logic [13:0] cnt_a, cnt_b;
  logic [7:0]  tens_a, ones_a, tens_b, ones_b;
  logic [1:0]  amax_a, amin_a, chg_a, amax_b, amin_b, chg_b;

  int   checks = 0;
  int   errors = 0;
  int   chg0_pulses = 0;
  int   ma[2];
  int   mb[2];
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  always #5 clk = ~clk;

  score_counter_multi #(.NUM_CH(2), .MAX_VAL(99), .CNT_BW(BW), .WRAP(1'b0)) u_sat (
    .clk_i(clk), .rst_i(rst), .up_i(up), .down_i(dn), .clear_i(clear),
    .cnt_o(cnt_a), .tens_o(tens_a), .ones_o(ones_a),
    .at_max_o(amax_a), .at_min_o(amin_a), .changed_o(chg_a)
  );

  score_counter_multi #(.NUM_CH(2), .MAX_VAL(99), .CNT_BW(BW), .WRAP(1'b1)) u_wrap (
    .clk_i(clk), .rst_i(rst), .up_i(up), .down_i(dn), .clear_i(clear),
    .cnt_o(cnt_b), .tens_o(tens_b), .ones_o(ones_b),
    .at_max_o(amax_b), .at_min_o(amin_b), .changed_o(chg_b)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int fld(input logic [13:0] v, input int c);
    return int'(v[c*BW +: BW]);
  endfunction

  function automatic int nxt(input int c, input bit u, input bit d, input bit wrap);
    if (u && !d) return (c == 99) ? (wrap ? 0 : 99) : c + 1;
    if (d && !u) return (c == 0) ? (wrap ? 99 : 0) : c - 1;
    return c;
  endfunction

  function automatic exp_t mk(input logic [1:0] chg, input int c0, input int c1);
    exp_t e;
    e.chg = chg;
    e.cnt = {7'(c1), 7'(c0)};
    return e;
  endfunction

  // Update both models for one event cycle and queue any visible change.
  task automatic expect_update(input logic [1:0] um, input logic [1:0] dm);
    int na[2];
    int nb[2];
    logic [1:0] ca, cb;
    for (int c = 0; c < 2; c++) begin
      na[c] = nxt(ma[c], um[c], dm[c], 1'b0);
      nb[c] = nxt(mb[c], um[c], dm[c], 1'b1);
      ca[c] = (na[c] != ma[c]);
      cb[c] = (nb[c] != mb[c]);
      ma[c] = na[c];
      mb[c] = nb[c];
    end
    if (ca != 2'b00) qa.push_back(mk(ca, ma[0], ma[1]));
    if (cb != 2'b00) qb.push_back(mk(cb, mb[0], mb[1]));
  endtask

  task automatic expect_clear();
    logic [1:0] ca, cb;
    for (int c = 0; c < 2; c++) begin
      ca[c] = (ma[c] != 0);
      cb[c] = (mb[c] != 0);
      ma[c] = 0;
      mb[c] = 0;
    end
    if (ca != 2'b00) qa.push_back(mk(ca, 0, 0));
    if (cb != 2'b00) qb.push_back(mk(cb, 0, 0));
  endtask

  task automatic pulse(input logic [1:0] um, input logic [1:0] dm);
    expect_update(um, dm);
    @(posedge clk); #1;
    up = um;
    dn = dm;
    repeat (4) @(posedge clk);
    #1;
    up = '0;
    dn = '0;
    repeat (4) @(posedge clk);
  endtask

  task automatic pulses(input int n, input logic [1:0] um);
    for (int i = 0; i < n; i++) pulse(um, 2'b00);
  endtask

  task automatic do_clear();
    expect_clear();
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 20) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d/%0d expected changes never seen, required 0/0", name, qa.size(),
               qb.size());
    end
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (chg_a != 2'b00) begin
        checks++;
        if (chg_a[0]) chg0_pulses++;
        if (qa.size() == 0) begin
          errors++;
          $display("FAIL sat_event: unexpected change chg=%b cnt=%h, required none", chg_a, cnt_a);
        end else begin
          ea = qa.pop_front();
          if ({chg_a, cnt_a} !== ea) begin
            errors++;
            $display("FAIL sat_event: got chg=%b cnt=%h required chg=%b cnt=%h", chg_a, cnt_a,
                     ea.chg, ea.cnt);
          end
        end
      end
      if (chg_b != 2'b00) begin
        checks++;
        if (qb.size() == 0) begin
          errors++;
          $display("FAIL wrap_event: unexpected change chg=%b cnt=%h, required none", chg_b, cnt_b);
        end else begin
          eb = qb.pop_front();
          if ({chg_b, cnt_b} !== eb) begin
            errors++;
            $display("FAIL wrap_event: got chg=%b cnt=%h required chg=%b cnt=%h", chg_b, cnt_b,
                     eb.chg, eb.cnt);
          end
        end
      end
    end
  end

  initial begin
    ma = '{0, 0};
    mb = '{0, 0};
    #1 rst = 1'b1;
    #2;
    chk("rst_cnt", int'(cnt_a), 0);
    chk("rst_at_min", int'(amin_a), 3);
    chk("rst_at_max", int'(amax_a), 0);
    chk("rst_changed", int'(chg_a), 0);
    chk("rst_bcd", int'({tens_a, ones_a}), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);

    // First pulse checked for two-edge latency, then four plain pulses.
    expect_update(2'b01, 2'b00);
    @(posedge clk); #1 up = 2'b01;
    @(posedge clk);
    @(posedge clk); #1;
    chk("latency_n1", fld(cnt_a, 0), 0);
    @(posedge clk); #1;
    chk("latency_n2", fld(cnt_a, 0), 1);
    repeat (2) @(posedge clk);
    #1 up = 2'b00;
    repeat (4) @(posedge clk);
    pulses(4, 2'b01);
    drain("drain_five");
    chk("five_cnt0", fld(cnt_a, 0), 5);
    chk("five_tens", int'(tens_a[3:0]), 0);
    chk("five_ones", int'(ones_a[3:0]), 5);
    chk("five_cnt1", fld(cnt_a, 1), 0);
    chk("five_pulses", chg0_pulses, 5);

    pulses(94, 2'b01);
    drain("drain_99");
    chk("at99_cnt", fld(cnt_a, 0), 99);
    chk("at99_at_max", int'(amax_a[0]), 1);
    chk("at99_bcd", int'({tens_a[3:0], ones_a[3:0]}), 8'h99);
    pulse(2'b01, 2'b00);
    drain("drain_sat_up");
    chk("sat_up_cnt", fld(cnt_a, 0), 99);
    chk("sat_up_at_max", int'(amax_a[0]), 1);
    chk("wrap_up_cnt", fld(cnt_b, 0), 0);
    chk("wrap_up_at_min", int'(amin_b[0]), 1);

    do_clear();
    pulse(2'b00, 2'b01);
    drain("drain_down");
    chk("sat_dn_cnt", fld(cnt_a, 0), 0);
    chk("sat_dn_at_min", int'(amin_a[0]), 1);
    chk("wrap_dn_cnt", fld(cnt_b, 0), 99);
    chk("wrap_dn_bcd", int'({tens_b[3:0], ones_b[3:0]}), 8'h99);

    do_clear();
    pulses(42, 2'b11);
    pulse(2'b10, 2'b10);
    drain("drain_both");
    chk("both_ev_cnt1", fld(cnt_a, 1), 42);
    expect_update(2'b10, 2'b00);
    @(posedge clk); #1 up = 2'b10;
    repeat (50) @(posedge clk);
    #1 up = 2'b00;
    repeat (4) @(posedge clk);
    drain("drain_held");
    chk("held_cnt1", fld(cnt_a, 1), 43);

    do_clear();
    pulses(12, 2'b11);
    pulses(25, 2'b01);
    drain("drain_37_12");
    chk("pre_clr_cnt0", fld(cnt_a, 0), 37);
    chk("pre_clr_cnt1", fld(cnt_a, 1), 12);
    // Clear lands on the same edge the ch0 up event would be applied.
    expect_clear();
    @(posedge clk); #1 up = 2'b01;
    @(posedge clk);
    @(posedge clk); #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    chk("clr_cnt", int'(cnt_a), 0);
    chk("clr_changed", int'(chg_a), 3);
    repeat (3) @(posedge clk);
    #1 up = 2'b00;
    repeat (4) @(posedge clk);
    drain("drain_clear");
    chk("clr_after", int'(cnt_a), 0);

    pulses(3, 2'b11);
    drain("drain_pre_rst");
    @(posedge clk); #1 up = 2'b01;
    #3 rst = 1'b1;
    #1;
    chk("async_rst_cnt_a", int'(cnt_a), 0);
    chk("async_rst_cnt_b", int'(cnt_b), 0);
    chk("async_rst_at_min", int'(amin_a), 3);
    ma = '{0, 0};
    mb = '{0, 0};
    qa.delete();
    qb.delete();
    up = 2'b00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    drain("drain_post_rst");
    chk("post_rst_cnt_a", int'(cnt_a), 0);
    chk("post_rst_cnt_b", int'(cnt_b), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/score_counter_multi.md
Name: score_counter_multi

Overview:
- Multi-channel scoreboard counter; successor to the single-channel two-clock up/down counter.
- All channels run on one system clock. Raw up/down button levels are synchronised and edge-detected per channel, so pulse-clocking is not used.
- Each channel holds a score in [0, MAX_VAL], with saturate or wrap mode and per-channel BCD digits for the 7-segment display path.
- Sits between the button inputs and the display multiplexer in the scoreboard top level.

Parameters:
- NUM_CH, 2, number of independent score channels (1..8).
- MAX_VAL, 99, upper count limit; must be <= 99.
- CNT_BW, 7, counter width; must satisfy 2**CNT_BW > MAX_VAL.
- WRAP, 0, 0 = saturate at limits; 1 = wrap MAX_VAL<->0.

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_i  in  1  asynchronous active-high reset.
- up_i  in  NUM_CH  raw count-up button level per channel; asynchronous to clk_i.
- down_i  in  NUM_CH  raw count-down button level per channel; asynchronous to clk_i.
- clear_i  in  1  synchronous clear of all channels; already synchronous to clk_i.
- cnt_o  out  NUM_CH*CNT_BW  packed binary counts; channel c occupies [c*CNT_BW +: CNT_BW].
- tens_o  out  NUM_CH*4  packed BCD tens digit per channel.
- ones_o  out  NUM_CH*4  packed BCD ones digit per channel.
- at_max_o  out  NUM_CH  channel count == MAX_VAL.
- at_min_o  out  NUM_CH  channel count == 0.
- changed_o  out  NUM_CH  one-cycle pulse: channel count changed this cycle.

Behaviour:
- Reset (rst_i high, asynchronous): all sync flops, edge registers and counts = 0; cnt_o/tens_o/ones_o = 0; at_min_o = all 1; at_max_o = 0; changed_o = 0. Release is synchronous to clk_i via a 2-flop reset synchroniser.
- Input path, per channel and per direction: s1 -> s2 (2-FF synchroniser) -> prev register. Event pulse = s2 & ~prev.
- One event per rising edge of the button level. A held level gives no further events.
- Latency: if edge N is the first to sample up_i high, cnt_o updates at edge N+2.
- Per-channel update at each edge, in priority order:
  1. clear_i = 1 -> count := 0. Pending events in the same cycle are discarded.
  2. Up and down events together -> no change.
  3. Up event only -> count+1. At MAX_VAL: stay at MAX_VAL if WRAP=0; go to 0 if WRAP=1.
  4. Down event only -> count-1. At 0: stay at 0 if WRAP=0; go to MAX_VAL if WRAP=1.
- Channels are fully independent; events on different channels in the same cycle are all applied.
- changed_o[c] is registered and high for exactly the one cycle in which cnt_o[c] shows its new value.
  - Stays 0 when a saturated event leaves the count unchanged.
  - Stays 0 on clear_i if the count was already 0.
- tens_o/ones_o and at_max_o/at_min_o are combinational from the count register. No extra latency; always consistent with cnt_o.
- The counter never holds a value > MAX_VAL. Any out-of-range value (unreachable by design) is forced to 0 on the next edge.
- rst_i asserted mid-operation clears everything immediately. Events in flight in the synchronisers are lost.

Test Plan:
- Reset, then pulse up_i[0] low->high->low 5 times, each level held 4 clocks -> cnt_o[0]=5, tens=0, ones=5; channel 1 stays 0; changed_o[0] pulses 5 times.
- WRAP=0, preload channel 0 to 99 via 99 up pulses, then 1 up pulse -> stays 99, at_max_o[0]=1, no changed_o pulse. From 0, 1 down pulse -> stays 0, at_min_o[0]=1.
- WRAP=1: at 99, 1 up pulse -> 0. At 0, 1 down pulse -> 99, tens=9, ones=9.
- up_i[1] and down_i[1] rise on the same clock edge with count 42 -> count stays 42. up_i held high 50 clocks -> exactly one increment.
- Channel 0 = 37, channel 1 = 12; clear_i high for one cycle coinciding with an up pulse on channel 0 -> both counts 0 next edge, changed_o = 2'b11.
- rst_i asserted asynchronously between clock edges while up_i is rising -> outputs 0 immediately. After release, no spurious increment.
